// File: rtl/sif_xfer_ctrl_pkg.sv
// Shared definitions for the serial exchange controller: state encoding,
// engine direction levels and default phase timings.
package sif_xfer_ctrl_pkg;

  localparam int BIT_RB_A = 5;
  localparam int BIT_RB_D = 8;
  localparam int BIT_RND  = 4;

  localparam int DEF_SEND_CYCLES = 184;
  localparam int DEF_TIMEOUT     = 1024;

  localparam logic DIR_SEND = 1'b0;
  localparam logic DIR_RECV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/sif_xfer_ctrl_if.sv
// Bundle of the controller's sequencing, engine, host and bank signals.
// The slave view belongs to the controller, the master view to its surroundings.
interface sif_xfer_ctrl_if;
  import sif_xfer_ctrl_pkg::*;

  logic                start;
  logic [BIT_RND-1:0]  rounds;
  logic                busy;
  logic                done;
  logic                err_timeout;
  logic [BIT_RND-1:0]  round_cnt;

  logic                updown;
  logic                S_done;
  logic                eng_RB_RW;
  logic [BIT_RB_A-1:0] eng_RB_A;
  logic [BIT_RB_D-1:0] eng_RB_D;

  logic                host_req;
  logic                host_rw;
  logic [BIT_RB_A-1:0] host_a;
  logic [BIT_RB_D-1:0] host_d;
  logic                host_gnt;
  logic [BIT_RB_D-1:0] host_q;

  logic                RB_RW;
  logic [BIT_RB_A-1:0] RB_A;
  logic [BIT_RB_D-1:0] RB_D;
  logic [BIT_RB_D-1:0] RB_Q;

  modport master (
    output start, rounds, S_done, eng_RB_RW, eng_RB_A, eng_RB_D,
           host_req, host_rw, host_a, host_d, RB_Q,
    input  busy, done, err_timeout, round_cnt, updown, host_gnt, host_q,
           RB_RW, RB_A, RB_D
  );

  modport slave (
    input  start, rounds, S_done, eng_RB_RW, eng_RB_A, eng_RB_D,
           host_req, host_rw, host_a, host_d, RB_Q,
    output busy, done, err_timeout, round_cnt, updown, host_gnt, host_q,
           RB_RW, RB_A, RB_D
  );

endinterface

// File: rtl/sif_rb_mux.sv
// Register-bank request multiplexer: the host owns the bank while granted,
// otherwise the serial engine does.
module sif_rb_mux
  import sif_xfer_ctrl_pkg::*;
(
  input  logic                host_gnt,
  input  logic                host_rw,
  input  logic [BIT_RB_A-1:0] host_a,
  input  logic [BIT_RB_D-1:0] host_d,
  input  logic                eng_rw,
  input  logic [BIT_RB_A-1:0] eng_a,
  input  logic [BIT_RB_D-1:0] eng_d,
  output logic                rb_rw,
  output logic [BIT_RB_A-1:0] rb_a,
  output logic [BIT_RB_D-1:0] rb_d
);

  assign rb_rw = host_gnt ? host_rw : eng_rw;
  assign rb_a  = host_gnt ? host_a  : eng_a;
  assign rb_d  = host_gnt ? host_d  : eng_d;

endmodule

// File: rtl/sif_xfer_ctrl.sv
// Exchange sequencer for the serial engine: alternates send/receive phases,
// watches for stalled receives and hands the register bank to the host when idle.
module sif_xfer_ctrl
  import sif_xfer_ctrl_pkg::*;
#(
  parameter int SEND_CYCLES = DEF_SEND_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  sif_xfer_ctrl_if.slave bus
);

  localparam int MAX_CYC = (TIMEOUT > SEND_CYCLES) ? TIMEOUT : SEND_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(SEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECV_LOAD = CNT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_RND-1:0]   rounds_q, rounds_d;
  logic [BIT_RND-1:0]   round_cnt_q, round_cnt_d;
  logic [BIT_RND-1:0]   round_inc;
  logic                 err_q, err_d;
  logic                 gnt_q, gnt_d;
  logic                 s_done_q;
  logic                 s_done_rise;
  logic                 start_acc;

  assign s_done_rise = bus.S_done && !s_done_q;
  assign round_inc   = round_cnt_q + 1'b1;

  // The engine updates on the falling edge, so the whole controller does too.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rounds_q    <= '0;
      round_cnt_q <= '0;
      err_q       <= 1'b0;
      gnt_q       <= 1'b0;
      s_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rounds_q    <= rounds_d;
      round_cnt_q <= round_cnt_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      s_done_q    <= bus.S_done;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rounds_d    = rounds_q;
    round_cnt_d = round_cnt_q;
    err_d       = err_q;
    start_acc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A granted host blocks new sequences until it lets go of the bank.
        if (bus.start && (bus.rounds != '0) && !gnt_q) begin
          start_acc   = 1'b1;
          rounds_d    = bus.rounds;
          round_cnt_d = '0;
          err_d       = 1'b0;
          cnt_d       = SEND_LOAD;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == '0) begin
          cnt_d   = RECV_LOAD;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECV: begin
        // A completion arriving on the last watchdog cycle still counts.
        if (s_done_rise) begin
          round_cnt_d = round_inc;
          if (round_inc == rounds_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = SEND_LOAD;
            state_d = ST_SEND;
          end
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    gnt_d = bus.host_req && (gnt_q || ((state_q == ST_IDLE) && !start_acc));
  end

  // Direction decodes straight from state so reset returns the engine to receive at once.
  assign bus.updown      = (state_q == ST_SEND) ? DIR_SEND : DIR_RECV;
  assign bus.busy        = (state_q == ST_SEND) || (state_q == ST_RECV) || (state_q == ST_DONE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err_timeout = err_q;
  assign bus.round_cnt   = round_cnt_q;
  assign bus.host_gnt    = gnt_q;
  assign bus.host_q      = bus.RB_Q;

  sif_rb_mux u_rb_mux (
    .host_gnt (gnt_q),
    .host_rw  (bus.host_rw),
    .host_a   (bus.host_a),
    .host_d   (bus.host_d),
    .eng_rw   (bus.eng_RB_RW),
    .eng_a    (bus.eng_RB_A),
    .eng_d    (bus.eng_RB_D),
    .rb_rw    (bus.RB_RW),
    .rb_a     (bus.RB_A),
    .rb_d     (bus.RB_D)
  );

endmodule

// File: tb/tb_sif_xfer_ctrl.sv
// Scoreboard bench for sif_xfer_ctrl: sequence outcomes are predicted from phase
// lengths and engine response delays, then matched against done/err events.
module tb_sif_xfer_ctrl;
  import sif_xfer_ctrl_pkg::*;

  localparam int SEND_CYCLES = 184;
  localparam int TIMEOUT     = 1024;
  localparam int NEVER       = 100000;

  typedef struct {
    bit                 is_err;
    logic [BIT_RND-1:0] rcnt;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sif_xfer_ctrl_if bus ();

  sif_xfer_ctrl #(
    .SEND_CYCLES (SEND_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   d_q[$];
  logic [BIT_RND-1:0] last_rcnt = '0;
  bit   skip_run = 1'b0;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: raises S_done on the d-th receive cycle, drops it once the phase ends.
  initial begin
    int rcnt  = 0;
    int cur_d = NEVER;
    bus.S_done = 1'b0;
    forever begin
      @(posedge clk);
      if (rst || !bus.busy || bus.updown == DIR_SEND) begin
        rcnt       = 0;
        bus.S_done = 1'b0;
      end else begin
        if (rcnt == 0) cur_d = (d_q.size() > 0) ? d_q.pop_front() : NEVER;
        rcnt++;
        if (rcnt == cur_d) bus.S_done = 1'b1;
      end
    end
  end

  // Monitor: pops a prediction on each done pulse or watchdog event.
  initial begin
    bit   err_prev  = 1'b0;
    bit   upd_prev  = 1'b1;
    bit   pend_done = 1'b0;
    int   low_run   = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      if (pend_done) begin
        check("busy_falls_with_done", {bus.busy, bus.done}, 2'b00);
        pend_done = 1'b0;
      end
      if (bus.done || (bus.err_timeout && !err_prev)) begin
        check("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("event_kind", bus.err_timeout && !bus.done, e.is_err);
          check("event_round_cnt", bus.round_cnt, e.rcnt);
          check("event_cycle", cyc, e.cyc);
          check("event_busy", bus.busy, !e.is_err);
          if (bus.done) pend_done = 1'b1;
        end
      end
      if (bus.updown == DIR_SEND) low_run++;
      else if (!upd_prev) begin
        if (!skip_run) check("send_phase_len", low_run, SEND_CYCLES);
        skip_run = 1'b0;
        low_run  = 0;
      end
      err_prev = bus.err_timeout;
      upd_prev = bus.updown;
    end
  end

  task automatic launch(input logic [BIT_RND-1:0] r, input int d [3]);
    exp_t e;
    int   t;
    @(posedge clk);
    t = cyc + 1;
    e.is_err = 1'b0;
    e.rcnt   = r;
    for (int i = 0; i < int'(r); i++) begin
      d_q.push_back(d[i]);
      t += SEND_CYCLES;
      if (d[i] > TIMEOUT) begin
        e.is_err = 1'b1;
        e.rcnt   = BIT_RND'(i);
        t += TIMEOUT;
        break;
      end
      t += d[i];
    end
    e.cyc = t;
    exp_q.push_back(e);
    last_rcnt  = e.rcnt;
    bus.start  = 1'b1;
    bus.rounds = r;
    @(posedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((bus.busy || exp_q.size() != 0) && n < budget);
    check("seq_idle", {bus.busy, exp_q.size() == 0}, 2'b01);
  endtask

  task automatic run_seq(input logic [BIT_RND-1:0] r, input int d [3]);
    launch(r, d);
    wait_idle(5000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [BIT_RB_A-1:0] a;
    logic [BIT_RB_D-1:0] dv, q;
    logic                rw;
    int                  n;
    logic [BIT_RND-1:0]  r;
    int                  dd [3];

    bus.start = 1'b0; bus.rounds = '0;
    bus.eng_RB_RW = 1'b0; bus.eng_RB_A = '0; bus.eng_RB_D = '0;
    bus.host_req = 1'b0; bus.host_rw = 1'b1; bus.host_a = '0; bus.host_d = '0;
    bus.RB_Q = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_updown", bus.updown, 1);
    check("rst_outputs", {bus.busy, bus.done, bus.err_timeout, bus.host_gnt}, 4'b0000);
    check("rst_round_cnt", bus.round_cnt, 0);
    rst = 1'b0;

    // Two rounds, engine answers 300 cycles into each receive.
    run_seq(2, '{300, 300, 0});
    check("round_cnt_after_2", bus.round_cnt, 2);

    // Stalled receive trips the watchdog; the next start clears it.
    run_seq(1, '{NEVER, 0, 0});
    check("err_sticky", {bus.err_timeout, bus.busy, bus.updown}, 3'b101);
    launch(1, '{50, 0, 0});
    #1;
    check("err_cleared_on_start", {bus.err_timeout, bus.busy}, 2'b01);
    wait_idle(5000);

    // Watchdog boundaries: last permitted cycle and one beyond.
    run_seq(1, '{TIMEOUT, 0, 0});
    check("edge_on_last_cycle_no_err", bus.err_timeout, 0);
    run_seq(1, '{TIMEOUT + 1, 0, 0});
    check("one_past_timeout_err", bus.err_timeout, 1);
    run_seq(1, '{1, 0, 0});

    // rounds=0 is not a sequence.
    @(posedge clk);
    bus.start = 1'b1; bus.rounds = '0;
    @(posedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      #1;
      check("rounds0_ignored", {bus.busy, bus.updown}, 2'b01);
      check("rounds0_round_cnt", bus.round_cnt, last_rcnt);
      @(posedge clk);
    end

    // Engine owns the bank while the host is not granted.
    for (int i = 0; i < 4; i++) begin
      rw = 1'($urandom); a = BIT_RB_A'($urandom); dv = BIT_RB_D'($urandom);
      bus.eng_RB_RW = rw; bus.eng_RB_A = a; bus.eng_RB_D = dv;
      #1;
      check("eng_to_bank", {bus.RB_RW, bus.RB_A, bus.RB_D}, {rw, a, dv});
    end

    // Start and host request together: start wins, grant follows DONE.
    @(posedge clk);
    d_q.push_back(10);
    exp_q.push_back('{1'b0, 4'd1, cyc + 1 + SEND_CYCLES + 10});
    last_rcnt = 1;
    bus.start = 1'b1; bus.rounds = 1; bus.host_req = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_beats_host", {bus.busy, bus.host_gnt}, 2'b10);
    n = 0;
    while (!bus.done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", bus.done, 1);
    @(posedge clk); #1;
    check("gnt_after_done_idle", {bus.host_gnt, bus.busy}, 2'b00);
    @(posedge clk); #1;
    check("gnt_rises", bus.host_gnt, 1);

    bus.host_rw = 1'b0; bus.host_a = 5'd3; bus.host_d = 8'hA5;
    q = BIT_RB_D'($urandom); bus.RB_Q = q;
    #1;
    check("host_write_on_bank", {bus.RB_RW, bus.RB_A, bus.RB_D}, {1'b0, 5'd3, 8'hA5});
    check("host_q_passthru", bus.host_q, q);

    // Start while the host holds the bank is ignored.
    @(posedge clk);
    bus.start = 1'b1; bus.rounds = 1;
    @(posedge clk);
    bus.start = 1'b0;
    #1;
    check("start_ignored_while_gnt", {bus.busy, bus.host_gnt}, 2'b01);
    @(posedge clk); #1;
    check("still_idle_while_gnt", bus.busy, 0);
    bus.host_req = 1'b0;
    @(posedge clk); #1;
    check("gnt_released", bus.host_gnt, 0);
    run_seq(1, '{20, 0, 0});

    // Randomised sequences, occasionally with a stalled round.
    for (int k = 0; k < 6; k++) begin
      r = BIT_RND'($urandom_range(1, 3));
      for (int j = 0; j < 3; j++)
        dd[j] = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 + $urandom_range(0, 50)
                                            : $urandom_range(1, 400);
      run_seq(r, dd);
    end

    // Asynchronous reset in the middle of a send phase.
    launch(2, '{40, 40, 0});
    repeat (50) @(posedge clk);
    skip_run = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_updown", bus.updown, 1);
    check("async_rst_busy", bus.busy, 0);
    exp_q.delete();
    d_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_round_cnt", bus.round_cnt, 0);
    run_seq(1, '{5, 0, 0});

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sif_xfer_ctrl.md
Name: sif_xfer_ctrl

Overview:
Sequences the serial transmit/receive engine through complete exchange rounds. It drives the engine's updown direction, times the send phase, and waits for S_done at the end of each receive phase. A watchdog flags a stalled receive. It also arbitrates the single-port register bank between the engine and a host port, so the host can inspect or preload the bank only while no exchange is running.

Parameters:
SEND_CYCLES, 184, clk cycles updown is held low per send phase (covers 8 columns × 22 cycles plus sync margin)
TIMEOUT, 1024, max clk cycles in a receive phase waiting for S_done before error
BIT_RB_A, 5, bank address width
BIT_RB_D, 8, bank data width
BIT_RND, 4, width of the round-count request

Ports:
clk  in  1  clock; all state updates on the falling edge, matching the serial engine
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin an exchange sequence
rounds  in  BIT_RND  number of send+receive rounds; sampled on accepted start
busy  out  1  high from accepted start until the sequence ends
done  out  1  one-cycle pulse when all rounds complete
err_timeout  out  1  sticky watchdog error; cleared by the next accepted start
round_cnt  out  BIT_RND  rounds completed in the current or last sequence
updown  out  1  to engine: 0 = send, 1 = receive/idle
S_done  in  1  from engine: receive phase complete (level)
eng_RB_RW, eng_RB_A, eng_RB_D  in  1/BIT_RB_A/BIT_RB_D  engine bank request
host_req  in  1  host requests bank access (level)
host_rw, host_a, host_d  in  1/BIT_RB_A/BIT_RB_D  host bank request (rw: 0 = W, 1 = R)
host_gnt  out  1  host owns the bank
RB_RW, RB_A, RB_D  out  1/BIT_RB_A/BIT_RB_D  to bank
RB_Q  in  BIT_RB_D  bank read data, passed to host_q
host_q  out  BIT_RB_D  host read data (RB_Q, unregistered)

Behaviour:
- Reset values: state IDLE, updown=1, busy=0, done=0, err_timeout=0, round_cnt=0, host_gnt=0, cycle counter 0, S_done edge register 0.
- FSM states: IDLE, SEND, RECV, DONE, ERR.
- IDLE:
  - start=1 and rounds!=0: latch rounds, clear round_cnt and err_timeout, load counter with SEND_CYCLES-1, go to SEND.
  - start=1 with rounds=0: ignored; state stays IDLE, busy stays 0.
- SEND:
  - updown=0; counter decrements each cycle.
  - Counter at 0: go to RECV, load counter with TIMEOUT-1.
- RECV:
  - updown=1; detect an S_done rising edge (S_done=1 while the previous sample was 0).
  - On edge: round_cnt+1; if the new round_cnt equals latched rounds, go to DONE, else go to SEND with the counter reloaded.
  - Counter reaches 0 with no edge: go to ERR. An edge arriving in the same cycle the counter hits 0 wins.
- DONE: done=1 for exactly this cycle; go to IDLE.
- ERR: set err_timeout; go to IDLE (updown stays 1).
- busy=1 in SEND, RECV and DONE; 0 in IDLE and ERR.
- start outside IDLE is ignored.
- Bank arbitration:
  - host_gnt is registered. It is set when state is IDLE, host_req=1 and no start is being accepted. It is cleared when host_req=0.
  - Start and host_req in the same IDLE cycle: start wins, host_gnt stays 0.
  - Start while host_gnt=1 is ignored; the host must release first.
  - RB_RW/RB_A/RB_D are combinational: host fields when host_gnt=1, else eng_* fields.
  - If the engine's bank signals are active while the host is granted, the engine is not connected to the bank; that is the host's responsibility.
- Reset mid-sequence forces IDLE with updown=1 immediately (asynchronously); the engine resynchronises through its own direction sampling.

Decomposition:
- Shared package: FSM state encodings, updown direction constants (SEND=0, RECV=1), default SEND_CYCLES/TIMEOUT.
- One natural sub-module: sif_rb_mux, the combinational bank multiplexer selected by host_gnt.

Test Plan:
- rounds=2, engine model asserts S_done 300 cycles into each RECV -> updown low 184 cycles, high, low 184, high; done pulse once; round_cnt=2; busy falls the same cycle as done.
- rounds=1, S_done never rises -> err_timeout=1 exactly 1024 cycles after updown rises; state IDLE; a following start with rounds=1 clears err_timeout.
- start with rounds=0 -> no busy, updown stays 1, round_cnt unchanged.
- Start and host_req in the same idle cycle -> busy=1, host_gnt=0; host_gnt rises one cycle after DONE; host write A=5'd3, D=8'hA5 appears on RB_* with RB_RW=0.
- host_gnt=1 and start pulsed -> ignored; after host_req drops, the next start is accepted.
- rst asserted mid-SEND -> updown=1 and busy=0 immediately, without waiting for a clock edge.
